fp32_mul_iter: RTL and testbench

FP32_MUL_ITER -- requirements
Module: fp32_mul_iter

---
 rtl/fp32_pkg.sv | 16 +
 rtl/fp32_mul_iter_lzc48.sv | 21 ++
 rtl/fp32_mul_iter.sv | 139 +++++++++++++
 tb/tb_fp32_mul_iter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared constants and FSM encoding for the iterative FP32 multiplier.
package fp32_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC00001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp32_mul_iter_lzc48.sv
// Combinational 48-bit leading-zero counter; returns 48 for an all-zero input.
module lzc48 (
    input  logic [47:0] v,
    output logic [5:0]  cnt
);

    logic found;

    // Scan from the MSB down, counting zeros until the first set bit.
    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/fp32_mul_iter.sv
// Iterative IEEE-754 single-precision multiplier: one shift-add step per
// cycle, truncating normalization, special operands short-circuit to DONE.
module fp32_mul_iter
    import fp32_pkg::*;
#(
    parameter logic [31:0] QNAN = QNAN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    state_t       state;
    logic         sign_r;
    logic [7:0]   ea_r, eb_r;
    logic [47:0]  mcand;
    logic [23:0]  mplier;
    logic [47:0]  prod;
    logic [4:0]   cnt;
    logic [31:0]  result_r;

    // Operand classification at the input boundary.
    logic a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic special, sign_in;
    logic [31:0] spec_res;

    assign a_exp_max = &a[30:23];
    assign b_exp_max = &b[30:23];
    assign a_nan     = a_exp_max &  (|a[22:0]);
    assign b_nan     = b_exp_max &  (|b[22:0]);
    assign a_inf     = a_exp_max & ~(|a[22:0]);
    assign b_inf     = b_exp_max & ~(|b[22:0]);
    assign a_zero    = ~(|a[30:0]);
    assign b_zero    = ~(|b[30:0]);
    assign sign_in   = a[31] ^ b[31];
    assign special   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // NaN and Inf*0 dominate, then infinity, then zero.
    always_comb begin
        spec_res = {sign_in, 31'b0};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_res = QNAN;
        else if (a_inf || b_inf)
            spec_res = {sign_in, 8'hFF, 23'b0};
    end

    // Normalization of the finished product; bit 46 carries weight 1.0.
    logic [5:0]         lz, lz46;
    logic signed [9:0]  exp_base, exp_n;
    logic [9:0]         shamt;
    logic [22:0]        mant, den;
    logic [31:0]        norm_res;

    lzc48 u_lzc (
        .v   (prod),
        .cnt (lz)
    );

    assign lz46     = lz - 6'd1;
    assign exp_base = $signed({2'b00, ea_r} + {2'b00, eb_r} - 10'(BIAS));

    // Pick the mantissa window and exponent, then map overflow/underflow.
    always_comb begin
        if (prod[47]) begin
            exp_n = exp_base + 10'sd1;
            mant  = prod[46:24];
        end else begin
            exp_n = exp_base - $signed({4'b0000, lz46});
            mant  = 23'((prod << lz46) >> 23);
        end
        shamt = 10'(10'sd1 - exp_n);
        den   = 23'({1'b1, mant} >> shamt[4:0]);

        if (exp_n >= $signed(10'(EXP_MAX)))
            norm_res = {sign_r, 8'hFF, 23'b0};
        else if (exp_n <= 10'sd0) begin
            if (shamt >= 10'd24) norm_res = {sign_r, 31'b0};
            else                 norm_res = {sign_r, 8'h00, den};
        end else
            norm_res = {sign_r, exp_n[7:0], mant};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_r <= sign_in;
                    ea_r   <= (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
                    eb_r   <= (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
                    mcand  <= {24'b0, |a[30:23], a[22:0]};
                    mplier <= {|b[30:23], b[22:0]};
                    prod   <= '0;
                    cnt    <= '0;
                    if (special) begin
                        result_r <= spec_res;
                        state    <= DONE;
                    end else begin
                        state    <= MUL;
                    end
                end
                MUL: begin
                    prod   <= prod + (mplier[0] ? mcand : 48'd0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd23) state <= NORM;
                end
                NORM: begin
                    result_r <= norm_res;
                    state    <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_r;

endmodule

// File: tb/tb_fp32_mul_iter.sv
// Directed-vector bench with a scoreboard queue and a decoupled monitor.
module tb_fp32_mul_iter;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;

    fp32_mul_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, value on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) check("unexpected out_valid", 32'd1, 32'd0);
                else                 check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                check("result", result, sbq[0].res);
                void'(sbq.pop_front());
            end
        end
        prev_ov <= out_valid;
    end

    // Present one operand pair for exactly one accepting edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input int lat, input bit push);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready timeout", 32'd0, 32'd1);
            return;
        end
        a = av; b = bv; in_valid = 1'b1;
        if (push) sbq.push_back('{er, lat, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            check("drain timeout", 32'd0, 32'd1);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    // Hand-computed vectors; latency 0 means valid in the cycle after acceptance.
    logic [31:0] va  [10] = '{32'h40000000, 32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F000000,
                              32'h00000001, 32'hC0000000, 32'h7FC00000, 32'h80000000, 32'h00800000};
    logic [31:0] vb  [10] = '{32'h40400000, 32'h3FC00000, 32'h00000000, 32'h40000000, 32'h7F000000,
                              32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h00800000};
    logic [31:0] vr  [10] = '{32'h40C00000, 32'h40100000, 32'h7FC00001, 32'hFF800000, 32'h7F800000,
                              32'h00000001, 32'hC0800000, 32'h7FC00001, 32'h80000000, 32'h00000000};
    int          vl  [10] = '{25, 25, 0, 0, 25, 25, 25, 0, 0, 25};

    initial begin
        int seen;
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i], vr[i], vl[i], 1'b1);
            drain();
        end

        // Back-pressure: hold the result for 5 cycles in DONE.
        out_ready = 1'b0;
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 25, 1'b1);
        w = 0;
        while (!out_valid && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("stall out_valid", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("stall result", result, 32'h40C00000);
            check("stall in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post-stall in_ready", {31'b0, in_ready}, 32'd1);
        check("post-stall out_valid", {31'b0, out_valid}, 32'd0);
        drain();

        // Reset ten cycles into MUL discards the operation.
        issue(32'h40000000, 32'h40400000, 32'h0, 0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("rst mid-op out_valid", 32'(seen), 32'd0);
        check("rst mid-op in_ready", {31'b0, in_ready}, 32'd1);
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 25, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
